// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared types and constants for the mul/div issue controller:
//                FSM state encoding, exception codes, status register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  // Issue controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Exception writeback target and codes.
  localparam int RSTATUS_REG   = 30;
  localparam int MULT_EXC_CODE = 4;
  localparam int DIV_EXC_CODE  = 5;

  // Width of the BUSY wait counter; holds any count up to 63.
  localparam int WAIT_CNT_W    = 6;

endpackage
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_issue_ctrl_if
//  Description : Bundle of the issue, multdiv-unit and writeback signals of
//                the mul/div issue controller. The controller side uses the
//                master modport; the surrounding pipeline/unit uses slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_issue_ctrl_if;

  // Issue side
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        stall;
  logic        flush;

  // Multdiv unit side
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  // Writeback side
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        timeout;

  modport master (
    input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
    input  md_result, md_exception, md_resultRDY, wb_ack,
    output issue_ready, stall, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    output wb_valid, wb_rd, wb_data, timeout
  );

  modport slave (
    output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
    output md_result, md_exception, md_resultRDY, wb_ack,
    input  issue_ready, stall, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    input  wb_valid, wb_rd, wb_data, timeout
  );

endinterface
`default_nettype wire

// File: rtl/multdiv_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_wait_counter
//  Description : BUSY-phase cycle counter with synchronous clear and enable.
//                Flags when the minimum wait has elapsed and when the last
//                permitted BUSY cycle is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_wait_counter
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int MIN_WAIT       = 2
) (
  input  logic clock,
  input  logic clrn,
  input  logic clear_i,
  input  logic enable_i,
  output logic min_wait_done_o,
  output logic timeout_hit_o
);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  // Clear wins over enable so the count is 0 on the first BUSY cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign min_wait_done_o = (count_q >= WAIT_CNT_W'(MIN_WAIT));
  assign timeout_hit_o   = (count_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_issue_ctrl
//  Description : Accepts one decoded mul/div instruction at a time, fires a
//                one-cycle start pulse to the multdiv unit, waits for its
//                result (with a minimum wait and a timeout), then presents a
//                writeback request until it is acknowledged. Exceptions and
//                timeouts write an exception code to the status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int MIN_WAIT       = 2,
  parameter int RSTATUS_REG    = multdiv_pkg::RSTATUS_REG,
  parameter int MULT_EXC_CODE  = multdiv_pkg::MULT_EXC_CODE,
  parameter int DIV_EXC_CODE   = multdiv_pkg::DIV_EXC_CODE
) (
  input  logic                 clock,
  input  logic                 clrn,
  multdiv_issue_ctrl_if.master bus
);

  import multdiv_pkg::state_e;
  import multdiv_pkg::ST_IDLE;
  import multdiv_pkg::ST_START;
  import multdiv_pkg::ST_BUSY;
  import multdiv_pkg::ST_DONE;

  state_e      state_q;
  state_e      state_d;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic [31:0] result_q;
  logic        exc_q;

  logic        accept;
  logic        capture;
  logic        force_exc;
  logic        in_busy;
  logic        min_wait_done;
  logic        timeout_hit;
  logic [31:0] exc_code;

  assign in_busy = (state_q == ST_BUSY);

  multdiv_wait_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MIN_WAIT       (MIN_WAIT)
  ) u_wait_cnt (
    .clock           (clock),
    .clrn            (clrn),
    .clear_i         (!in_busy),
    .enable_i        (in_busy),
    .min_wait_done_o (min_wait_done),
    .timeout_hit_o   (timeout_hit)
  );

  // State register.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; flush overrides every other event in the same cycle,
  // and a qualifying result on the last BUSY cycle beats the timeout.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    force_exc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.issue_valid && !bus.flush) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = bus.flush ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (min_wait_done && bus.md_resultRDY) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          force_exc = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.flush || bus.wb_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand/destination latch on accept, result capture at end of BUSY.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= bus.issue_a;
        b_q      <= bus.issue_b;
        rd_q     <= bus.issue_rd;
        is_div_q <= bus.issue_is_div;
      end
      if (capture) begin
        result_q <= bus.md_result;
        exc_q    <= bus.md_exception;
      end else if (force_exc) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
    end
  end

  assign exc_code = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

  assign bus.issue_ready = (state_q == ST_IDLE);
  assign bus.stall       = (state_q != ST_IDLE);
  assign bus.ctrl_MULT   = (state_q == ST_START) && !is_div_q;
  assign bus.ctrl_DIV    = (state_q == ST_START) &&  is_div_q;
  assign bus.md_operandA = a_q;
  assign bus.md_operandB = b_q;
  assign bus.timeout     = force_exc;
  assign bus.wb_valid    = (state_q == ST_DONE);

  // Writeback fields are only driven while the request is up; register 0 is
  // passed through untouched and left for the register file to discard.
  assign bus.wb_rd   = (state_q != ST_DONE) ? 5'd0 :
                       exc_q                ? 5'(RSTATUS_REG) : rd_q;
  assign bus.wb_data = (state_q != ST_DONE) ? 32'd0 :
                       exc_q                ? exc_code : result_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_issue_ctrl
//  Description : Scoreboard bench for multdiv_issue_ctrl. A driver issues
//                directed and random operations and pushes the expected start
//                pulse, writeback and timeout into queues; a monitor pops and
//                compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

  localparam int TO       = 48;
  localparam int MW       = 2;
  localparam int NEVER    = 1000;
  localparam int NO_FLUSH = -1000;

  typedef enum {END_ACK, END_FLUSH, END_RESET} end_e;
  typedef struct {logic is_div; logic [31:0] a; logic [31:0] b;} start_t;
  typedef struct {logic [4:0] rd; logic [31:0] data; int lat;} wb_t;

  logic clock = 1'b0;
  logic clrn;

  multdiv_issue_ctrl_if bus ();

  multdiv_issue_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .MIN_WAIT       (MW),
    .RSTATUS_REG    (30),
    .MULT_EXC_CODE  (4),
    .DIV_EXC_CODE   (5)
  ) dut (
    .clock (clock),
    .clrn  (clrn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  start_t exp_start_q[$];
  wb_t    exp_wb_q[$];
  int     exp_to_q[$];
  int     wb_exp_n = 0, to_exp_n = 0, wb_seen = 0, to_seen = 0;

  // ---------------------------------------------------------------- monitor
  int          start_cyc  = 0;
  logic        prev_valid = 1'b0;
  logic [4:0]  held_rd;
  logic [31:0] held_data;

  always @(negedge clock) begin
    start_t s;
    wb_t    w;
    int     o;
    if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      check("start_one_hot", 32'(bus.ctrl_MULT & bus.ctrl_DIV), 32'd0);
      check("start_expected", 32'(exp_start_q.size() != 0), 32'd1);
      if (exp_start_q.size() != 0) begin
        s = exp_start_q.pop_front();
        check("start_is_div", 32'(bus.ctrl_DIV), 32'(s.is_div));
        check("start_opA", bus.md_operandA, s.a);
        check("start_opB", bus.md_operandB, s.b);
      end
      start_cyc = cyc;
    end
    if (bus.timeout) begin
      to_seen++;
      check("timeout_expected", 32'(exp_to_q.size() != 0), 32'd1);
      if (exp_to_q.size() != 0) begin
        o = exp_to_q.pop_front();
        check("timeout_offset", 32'(cyc - start_cyc), 32'(o));
      end
    end
    if (bus.wb_valid && !prev_valid) begin
      wb_seen++;
      check("wb_expected", 32'(exp_wb_q.size() != 0), 32'd1);
      if (exp_wb_q.size() != 0) begin
        w = exp_wb_q.pop_front();
        check("wb_rd", 32'(bus.wb_rd), 32'(w.rd));
        check("wb_data", bus.wb_data, w.data);
        check("wb_latency", 32'(cyc - start_cyc), 32'(w.lat));
        check("wb_stall", 32'(bus.stall), 32'd1);
      end
      held_rd   = bus.wb_rd;
      held_data = bus.wb_data;
    end else if (bus.wb_valid) begin
      check("wb_rd_stable", 32'(bus.wb_rd), 32'(held_rd));
      check("wb_data_stable", bus.wb_data, held_data);
    end
    prev_valid = bus.wb_valid;
  end

  // ----------------------------------------------------------------- driver
  // rdy_from: first BUSY count at which RDY is driven high (-1 = from issue,
  // NEVER = never). flush_at: BUSY count carrying flush (-1 = START).
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy_from, input logic exc,
                        input logic [31:0] res, input int flush_at, input int ack_delay,
                        input end_e mode, input bit keep_rdy);
    int     first_ok, last, n;
    bit     to, flushed;
    logic   r;
    start_t s;
    wb_t    w;
    logic [31:0] code;

    n = 0;
    while (!bus.issue_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("ready_before_issue", 32'(bus.issue_ready), 32'd1);

    // Reference model: result accepted at the first RDY count not below the
    // minimum wait, otherwise the exception is forced on the last BUSY cycle.
    code     = is_div ? 32'd5 : 32'd4;
    first_ok = (rdy_from == NEVER) ? NEVER : ((rdy_from < MW) ? MW : rdy_from);
    to       = (first_ok > TO - 1);
    last     = to ? TO - 1 : first_ok;
    flushed  = (flush_at != NO_FLUSH) && (flush_at <= last);

    s.is_div = is_div; s.a = a; s.b = b;
    exp_start_q.push_back(s);
    if (!flushed) begin
      w.rd   = (to || exc) ? 5'd30 : rd;
      w.data = (to || exc) ? code  : res;
      w.lat  = last + 2;
      exp_wb_q.push_back(w);
      wb_exp_n++;
      if (to) begin
        exp_to_q.push_back(last + 1);
        to_exp_n++;
      end
    end

    bus.issue_valid  = 1'b1;
    bus.issue_is_div = is_div;
    bus.issue_a      = a;
    bus.issue_b      = b;
    bus.issue_rd     = rd;
    bus.md_resultRDY = (rdy_from != NEVER) && (rdy_from < 0);
    bus.md_result    = bus.md_resultRDY ? res : $urandom;
    bus.md_exception = bus.md_resultRDY ? exc : 1'b0;
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    bus.issue_a     = $urandom;
    bus.issue_b     = $urandom;

    for (int k = -1; k <= (flushed ? flush_at : last); k++) begin
      r = (rdy_from != NEVER) && (k >= rdy_from);
      bus.md_resultRDY = r;
      bus.md_result    = r ? res : $urandom;
      bus.md_exception = r ? exc : 1'($urandom);
      bus.flush        = (k == flush_at);
      @(posedge clock); #1;
    end
    bus.flush        = 1'b0;
    bus.md_resultRDY = keep_rdy;

    if (flushed) begin
      check("idle_after_flush", 32'(bus.issue_ready), 32'd1);
      check("no_wb_after_flush", 32'(bus.wb_valid), 32'd0);
      return;
    end
    check("done_reached", 32'(bus.wb_valid), 32'd1);
    if (!bus.wb_valid) return;

    repeat (ack_delay) begin
      bus.md_result    = $urandom;
      bus.md_exception = 1'($urandom);
      @(posedge clock); #1;
    end

    case (mode)
      END_ACK:   bus.wb_ack = 1'b1;
      END_FLUSH: bus.flush  = 1'b1;
      default: begin
        clrn = 1'b0;
        #1;
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_opA", bus.md_operandA, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
      end
    endcase
    @(posedge clock); #1;
    bus.wb_ack = 1'b0;
    bus.flush  = 1'b0;
    if (mode == END_RESET) clrn = 1'b1;
    check("idle_after_done", 32'(bus.issue_ready), 32'd1);
    check("wb_dropped", 32'(bus.wb_valid), 32'd0);
    if (keep_rdy) begin
      repeat (2) begin @(posedge clock); #1; end
      check("late_rdy_ignored", 32'(bus.stall), 32'd0);
    end
    bus.md_resultRDY = 1'b0;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    clrn             = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_a      = '0;
    bus.issue_b      = '0;
    bus.issue_rd     = '0;
    bus.flush        = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.wb_ack       = 1'b0;
    #1 clrn = 1'b0;
    #2;
    check("reset_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_ctrl", 32'({bus.ctrl_MULT, bus.ctrl_DIV}), 32'd0);
    check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset_timeout", 32'(bus.timeout), 32'd0);
    check("reset_operands", bus.md_operandA | bus.md_operandB, 32'd0);
    @(posedge clock); #1;
    clrn = 1'b1;

    // 6*7 with RDY at count 33
    run_op(1'b0, 32'd6, 32'd7, 5'd5, 33, 1'b0, 32'd42, NO_FLUSH, 2, END_ACK, 1'b0);
    // divide by zero raising an exception
    run_op(1'b1, 32'd10, 32'd0, 5'd3, 4, 1'b1, 32'd0, NO_FLUSH, 0, END_ACK, 1'b0);
    // RDY held from issue onward and beyond
    run_op(1'b0, 32'h1234, 32'h10, 5'd7, -1, 1'b0, 32'h12340, NO_FLUSH, 1, END_ACK, 1'b1);
    // RDY never comes: timeout
    run_op(1'b0, 32'd3, 32'd9, 5'd12, NEVER, 1'b0, 32'd27, NO_FLUSH, 0, END_ACK, 1'b0);
    // flush at count 10 before RDY at 12, then a normal op
    run_op(1'b1, 32'd100, 32'd7, 5'd9, 12, 1'b0, 32'd14, 10, 0, END_ACK, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 5'd9, 12, 1'b0, 32'd14, NO_FLUSH, 0, END_ACK, 1'b0);
    // flush during START keeps the pulse
    run_op(1'b0, 32'd5, 32'd5, 5'd1, 3, 1'b0, 32'd25, -1, 0, END_ACK, 1'b0);
    // flush on the would-be timeout cycle
    run_op(1'b1, 32'd8, 32'd2, 5'd4, NEVER, 1'b0, 32'd4, TO - 1, 0, END_ACK, 1'b0);
    // RDY first on the last BUSY cycle
    run_op(1'b0, 32'd2, 32'd3, 5'd6, TO - 1, 1'b0, 32'd6, NO_FLUSH, 0, END_ACK, 1'b0);
    // write to register 0 passes through
    run_op(1'b0, 32'd0, 32'd0, 5'd0, 2, 1'b0, 32'hDEAD_BEEF, NO_FLUSH, 0, END_ACK, 1'b0);
    // flush while DONE
    run_op(1'b1, 32'd9, 32'd3, 5'd11, 5, 1'b0, 32'd3, NO_FLUSH, 1, END_FLUSH, 1'b0);
    // reset while DONE, then accept right after release
    run_op(1'b0, 32'd4, 32'd4, 5'd2, 6, 1'b0, 32'd16, NO_FLUSH, 1, END_RESET, 1'b0);
    run_op(1'b1, 32'd40, 32'd8, 5'd13, 3, 1'b0, 32'd5, NO_FLUSH, 0, END_ACK, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int   rsel, rf, fa;
      end_e md;
      rsel = int'($urandom_range(0, 9));
      rf   = (rsel == 0) ? NEVER : (rsel == 1) ? -1 : int'($urandom_range(0, 50));
      fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 50)) - 1 : NO_FLUSH;
      md   = ($urandom_range(0, 9) == 0) ? END_FLUSH : END_ACK;
      run_op(1'($urandom), $urandom, $urandom, 5'($urandom), rf,
             1'($urandom_range(0, 3) == 0), $urandom, fa,
             int'($urandom_range(0, 3)), md, rf == -1);
    end

    repeat (5) @(posedge clock);
    #1;
    check("wb_count", 32'(wb_seen), 32'(wb_exp_n));
    check("timeout_count", 32'(to_seen), 32'(to_exp_n));
    check("wb_pending", 32'(exp_wb_q.size()), 32'd0);
    check("start_pending", 32'(exp_start_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
